// File: rtl/game_state_fsm.sv
// Game-flow controller for the frogger top level: tracks IDLE/PLAY/DEATH/GAME_OVER,
// remaining lives, the per-life countdown timer, and emits respawn / score-clear pulses.
module game_state_fsm #(
  parameter int unsigned TICK_CYCLES = 25000000,
  parameter int unsigned LEVEL_TIME  = 30,
  parameter int unsigned DEATH_TICKS = 2,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned WIN_SCORE   = 5
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start_Btn,
  input  logic       i_Collided,
  input  logic [6:0] i_Score,
  input  logic       i_Home_Reached,
  output logic [1:0] o_Current_State,
  output logic [2:0] o_Lives,
  output logic [5:0] o_Time_Left,
  output logic       o_Respawn,
  output logic       o_Clear_Score,
  output logic       o_Win
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAY      = 2'b01,
    DEATH     = 2'b10,
    GAME_OVER = 2'b11
  } state_t;

  localparam int unsigned   PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_CYCLES - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);
  localparam logic [5:0]    TIME_INIT  = 6'(LEVEL_TIME);
  localparam logic [5:0]    DEATH_INIT = 6'(DEATH_TICKS);
  localparam logic [6:0]    SCORE_WIN  = 7'(WIN_SCORE);

  state_t        state;
  logic [PW-1:0] prescale;
  logic [5:0]    death_cnt;
  logic          start_prev;

  logic start_edge;
  logic tick;
  logic timed_out;
  logic life_lost;
  logic won;

  assign o_Current_State = state;

  // Event decode from current registered state and inputs.
  // A home landing reloads the timer ahead of a coincident tick, so that
  // tick cannot also count as a timeout.
  always_comb begin
    start_edge = i_Start_Btn & ~start_prev;
    tick       = ((state == PLAY) || (state == DEATH)) && (prescale == TICK_LAST);
    timed_out  = tick && (o_Time_Left == 6'd1) && !i_Home_Reached;
    life_lost  = i_Collided || timed_out;
    won        = (i_Score >= SCORE_WIN);
  end

  // Single registered FSM: state, counters and all outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= IDLE;
      o_Lives       <= '0;
      o_Time_Left   <= '0;
      o_Respawn     <= 1'b0;
      o_Clear_Score <= 1'b0;
      o_Win         <= 1'b0;
      prescale      <= '0;
      death_cnt     <= '0;
      start_prev    <= 1'b1;
    end else begin
      start_prev    <= i_Start_Btn;
      o_Respawn     <= 1'b0;
      o_Clear_Score <= 1'b0;

      // Prescaler runs only while the game clock matters; transitions below
      // override this with a clear.
      if ((state == PLAY) || (state == DEATH)) begin
        prescale <= tick ? '0 : prescale + 1'b1;
      end else begin
        prescale <= '0;
      end

      case (state)
        IDLE: begin
          if (start_edge) begin
            state         <= PLAY;
            o_Lives       <= LIVES_INIT;
            o_Time_Left   <= TIME_INIT;
            o_Win         <= 1'b0;
            o_Clear_Score <= 1'b1;
            prescale      <= '0;
          end
        end

        PLAY: begin
          if (won) begin
            state    <= GAME_OVER;
            o_Win    <= 1'b1;
            prescale <= '0;
          end else if (life_lost) begin
            prescale <= '0;
            if (timed_out) begin
              o_Time_Left <= '0;
            end
            if (o_Lives > 3'd1) begin
              state     <= DEATH;
              o_Lives   <= o_Lives - 3'd1;
              death_cnt <= DEATH_INIT;
              o_Respawn <= 1'b1;
            end else begin
              state   <= GAME_OVER;
              o_Lives <= '0;
              o_Win   <= 1'b0;
            end
          end else if (i_Home_Reached) begin
            o_Time_Left <= TIME_INIT;
          end else if (tick) begin
            o_Time_Left <= o_Time_Left - 6'd1;
          end
        end

        DEATH: begin
          if (tick) begin
            if (death_cnt <= 6'd1) begin
              state       <= PLAY;
              death_cnt   <= '0;
              o_Time_Left <= TIME_INIT;
              prescale    <= '0;
            end else begin
              death_cnt <= death_cnt - 6'd1;
            end
          end
        end

        GAME_OVER: begin
          if (start_edge) begin
            state    <= IDLE;
            o_Win    <= 1'b0;
            prescale <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          prescale <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_fsm.sv
// Scoreboard bench for game_state_fsm: stimulus phases push expected output
// snapshots tagged with the cycle they must appear on; a monitor pops and compares.
module tb_game_state_fsm;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_Start_Btn;
  logic       i_Collided;
  logic [6:0] i_Score;
  logic       i_Home_Reached;
  logic [1:0] o_Current_State;
  logic [2:0] o_Lives;
  logic [5:0] o_Time_Left;
  logic       o_Respawn;
  logic       o_Clear_Score;
  logic       o_Win;

  game_state_fsm #(
    .TICK_CYCLES(4),
    .LEVEL_TIME (3),
    .DEATH_TICKS(2),
    .START_LIVES(2),
    .WIN_SCORE  (5)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_Start_Btn    (i_Start_Btn),
    .i_Collided     (i_Collided),
    .i_Score        (i_Score),
    .i_Home_Reached (i_Home_Reached),
    .o_Current_State(o_Current_State),
    .o_Lives        (o_Lives),
    .o_Time_Left    (o_Time_Left),
    .o_Respawn      (o_Respawn),
    .o_Clear_Score  (o_Clear_Score),
    .o_Win          (o_Win)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int         at;
    string      name;
    logic [1:0] st;
    logic [2:0] lv;
    logic [5:0] tl;
    logic       rs;
    logic       cs;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   failed = 0;
  exp_t e;

  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic push(input int at, input string nm, input logic [1:0] st,
                      input logic [2:0] lv, input logic [5:0] tl,
                      input logic rs, input logic cs, input logic w);
    exp_t x;
    x.at = at; x.name = nm; x.st = st; x.lv = lv; x.tl = tl;
    x.rs = rs; x.cs = cs; x.w = w;
    sb.push_back(x);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due on this cycle, away from the active edge.
  always @(negedge i_Clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      tests++;
      if (e.at < cyc) begin
        failed++;
        $display("FAIL %s: expected at cycle %0d, not checked until %0d", e.name, e.at, cyc);
      end else if ({o_Current_State, o_Lives, o_Time_Left, o_Respawn, o_Clear_Score, o_Win} !==
                   {e.st, e.lv, e.tl, e.rs, e.cs, e.w}) begin
        failed++;
        $display("FAIL %s @%0d: got st=%0d lives=%0d time=%0d resp=%0b clr=%0b win=%0b, want st=%0d lives=%0d time=%0d resp=%0b clr=%0b win=%0b",
                 e.name, cyc, o_Current_State, o_Lives, o_Time_Left, o_Respawn, o_Clear_Score, o_Win,
                 e.st, e.lv, e.tl, e.rs, e.cs, e.w);
      end
    end
  end

  initial begin
    i_Reset = 1'b1; i_Start_Btn = 1'b0; i_Collided = 1'b0;
    i_Score = '0;   i_Home_Reached = 1'b0;

    // Reset state
    push(2, "reset_state", 2'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    wait_cyc(2);
    i_Reset = 1'b0;

    // Start, then timeout into DEATH and back to PLAY
    wait_cyc(3);
    push(3,  "idle_after_reset", 2'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    push(4,  "start_play",       2'd1, 3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    push(5,  "clear_once",       2'd1, 3'd2, 6'd3, 1'b0, 1'b0, 1'b0);
    push(7,  "time3_hold",       2'd1, 3'd2, 6'd3, 1'b0, 1'b0, 1'b0);
    push(8,  "time2",            2'd1, 3'd2, 6'd2, 1'b0, 1'b0, 1'b0);
    push(12, "time1",            2'd1, 3'd2, 6'd1, 1'b0, 1'b0, 1'b0);
    push(16, "timeout_death",    2'd2, 3'd1, 6'd0, 1'b1, 1'b0, 1'b0);
    push(17, "respawn_once",     2'd2, 3'd1, 6'd0, 1'b0, 1'b0, 1'b0);
    push(20, "death_ignores",    2'd2, 3'd1, 6'd0, 1'b0, 1'b0, 1'b0);
    push(23, "death_hold",       2'd2, 3'd1, 6'd0, 1'b0, 1'b0, 1'b0);
    push(24, "death_to_play",    2'd1, 3'd1, 6'd3, 1'b0, 1'b0, 1'b0);
    i_Start_Btn = 1'b1;
    wait_cyc(4);
    i_Start_Btn = 1'b0;
    wait_cyc(19);
    i_Collided = 1'b1; i_Home_Reached = 1'b1; i_Score = 7'd5;
    wait_cyc(20);
    i_Collided = 1'b0; i_Home_Reached = 1'b0; i_Score = 7'd0;

    // Start ignored in PLAY; home reload beats coincident tick
    wait_cyc(24);
    push(26, "start_in_play",   2'd1, 3'd1, 6'd3, 1'b0, 1'b0, 1'b0);
    push(28, "tick_to_2",       2'd1, 3'd1, 6'd2, 1'b0, 1'b0, 1'b0);
    push(32, "home_beats_tick", 2'd1, 3'd1, 6'd3, 1'b0, 1'b0, 1'b0);
    push(36, "tick_after_home", 2'd1, 3'd1, 6'd2, 1'b0, 1'b0, 1'b0);
    wait_cyc(25);
    i_Start_Btn = 1'b1;
    wait_cyc(26);
    i_Start_Btn = 1'b0;
    wait_cyc(31);
    i_Home_Reached = 1'b1;
    wait_cyc(32);
    i_Home_Reached = 1'b0;

    // Last life lost -> GAME_OVER, then start -> IDLE
    push(38, "last_life_over", 2'd3, 3'd0, 6'd2, 1'b0, 1'b0, 1'b0);
    push(39, "over_hold",      2'd3, 3'd0, 6'd2, 1'b0, 1'b0, 1'b0);
    push(41, "over_to_idle",   2'd0, 3'd0, 6'd2, 1'b0, 1'b0, 1'b0);
    wait_cyc(37);
    i_Collided = 1'b1;
    wait_cyc(38);
    i_Collided = 1'b0;
    wait_cyc(40);
    i_Start_Btn = 1'b1;
    wait_cyc(41);
    i_Start_Btn = 1'b0;

    // Win beats coincident collision
    push(43, "restart_play", 2'd1, 3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    push(45, "win_priority", 2'd3, 3'd2, 6'd3, 1'b0, 1'b0, 1'b1);
    push(46, "win_hold",     2'd3, 3'd2, 6'd3, 1'b0, 1'b0, 1'b1);
    push(48, "win_to_idle",  2'd0, 3'd2, 6'd3, 1'b0, 1'b0, 1'b0);
    wait_cyc(42);
    i_Start_Btn = 1'b1;
    wait_cyc(43);
    i_Start_Btn = 1'b0;
    wait_cyc(44);
    i_Score = 7'd5; i_Collided = 1'b1;
    wait_cyc(45);
    i_Score = 7'd0; i_Collided = 1'b0;
    wait_cyc(47);
    i_Start_Btn = 1'b1;
    wait_cyc(48);
    i_Start_Btn = 1'b0;

    // Start held through reset, fresh press, reset mid-DEATH
    push(50, "reset_held_start", 2'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    push(52, "no_edge_release",  2'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    push(53, "still_idle",       2'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    push(55, "fresh_start",      2'd1, 3'd2, 6'd3, 1'b0, 1'b1, 1'b0);
    push(57, "collide_death",    2'd2, 3'd1, 6'd3, 1'b1, 1'b0, 1'b0);
    push(58, "reset_mid_death",  2'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    push(59, "idle_post_reset",  2'd0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    wait_cyc(49);
    i_Reset = 1'b1; i_Start_Btn = 1'b1;
    wait_cyc(51);
    i_Reset = 1'b0;
    wait_cyc(53);
    i_Start_Btn = 1'b0;
    wait_cyc(54);
    i_Start_Btn = 1'b1;
    wait_cyc(55);
    i_Start_Btn = 1'b0;
    wait_cyc(56);
    i_Collided = 1'b1;
    wait_cyc(57);
    i_Collided = 1'b0; i_Reset = 1'b1;
    wait_cyc(58);
    i_Reset = 1'b0;

    wait_cyc(62);
    if (sb.size() != 0) begin
      tests  += sb.size();
      failed += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
GAME_STATE_FSM -- requirements
Module: game_state_fsm

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter TICK_CYCLES, default 25000000, giving the clock cycles per game tick (1 s at 25 MHz).
REQ-002 The block SHALL have parameter LEVEL_TIME, default 30, giving the ticks allowed per life, with range 1..63.
REQ-003 The block SHALL have parameter DEATH_TICKS, default 2, giving the ticks spent in the DEATH pause, with range 1..63.
REQ-004 The block SHALL have parameter START_LIVES, default 3, giving the lives loaded at game start, with range 1..7.
REQ-005 The block SHALL have parameter WIN_SCORE, default 5, giving the score that ends the game as a win, with range 1..127.
Ports (name, direction, width, meaning):
REQ-006 The block SHALL have a port i_Clk, input, 1 bit, which is the single system clock; all logic SHALL be on its rising edge.
REQ-007 The block SHALL have a port i_Reset, input, 1 bit, which is a synchronous, active-high reset.
REQ-008 The block SHALL have a port i_Start_Btn, input, 1 bit, which is the debounced start button level.
REQ-009 The block SHALL have a port i_Collided, input, 1 bit, which is the frog-hit level from the collision logic.
REQ-010 The block SHALL have a port i_Score, input, 7 bits, which is the current score from frogger control.
REQ-011 The block SHALL have a port i_Home_Reached, input, 1 bit, which is a 1-cycle pulse when the frog lands on a home pad.
REQ-012 The block SHALL have a port o_Current_State, output, 2 bits, with encoding 00 IDLE, 01 PLAY, 10 DEATH, 11 GAME_OVER.
REQ-013 The block SHALL have a port o_Lives, output, 3 bits, which is the remaining lives.
REQ-014 The block SHALL have a port o_Time_Left, output, 6 bits, which is the remaining ticks for the current life.
REQ-015 The block SHALL have a port o_Respawn, output, 1 bit, which is a 1-cycle pulse requesting a frog reposition.
REQ-016 The block SHALL have a port o_Clear_Score, output, 1 bit, which is a 1-cycle pulse requesting a score reset.
REQ-017 The block SHALL have a port o_Win, output, 1 bit, which is high while in GAME_OVER after a win.

Function
REQ-018 Start edge SHALL be defined as i_Start_Btn=1 with the registered previous sample =0; the previous sample SHALL reset to 1 so a button held through reset gives no edge.
REQ-019 The tick prescaler SHALL count 0..TICK_CYCLES-1 only in PLAY and DEATH, asserting an internal tick in the cycle it equals TICK_CYCLES-1, then wrapping to 0.
REQ-020 The prescaler SHALL clear to 0 on every state transition.
REQ-021 In IDLE, a start edge SHALL cause a move to PLAY next cycle, with o_Lives=START_LIVES, o_Time_Left=LEVEL_TIME, o_Win=0, and o_Clear_Score=1 for that one cycle.
REQ-022 In PLAY, on a tick, o_Time_Left SHALL decrement by 1; a tick while o_Time_Left=1 SHALL be a timeout, with o_Time_Left reaching 0.
REQ-023 In PLAY, i_Home_Reached=1 SHALL reload o_Time_Left=LEVEL_TIME and SHALL take precedence over a coincident tick decrement.
REQ-024 In PLAY, a life-loss event SHALL be i_Collided=1 or a timeout.
REQ-025 On a life-loss event with o_Lives>1, the block SHALL move to DEATH, decrement o_Lives, load the death counter with DEATH_TICKS, and pulse o_Respawn for 1 cycle.
REQ-026 On a life-loss event with o_Lives=1, the block SHALL move to GAME_OVER with o_Lives=0 and o_Win=0, and SHALL not pulse o_Respawn.
REQ-027 In PLAY, i_Score>=WIN_SCORE SHALL cause a move to GAME_OVER with o_Win=1; a win SHALL take priority over a coincident life-loss event, and o_Lives SHALL be unchanged.
REQ-028 In DEATH, the death counter SHALL decrement on each tick; the tick that takes it 1->0 SHALL cause a move to PLAY with o_Time_Left=LEVEL_TIME.
REQ-029 In DEATH, i_Collided, i_Home_Reached and i_Score SHALL be ignored.
REQ-030 In GAME_OVER, all outputs SHALL hold; a start edge SHALL cause a move to IDLE with o_Win=0, and o_Lives and o_Time_Left held.
REQ-031 A start edge in PLAY or DEATH SHALL be ignored.
REQ-032 o_Respawn and o_Clear_Score SHALL never be high for two consecutive cycles.
REQ-033 All outputs SHALL be registered, and a state change SHALL be visible on o_Current_State one cycle after the causing input.

Reset
REQ-034 i_Reset=1 at a clock edge SHALL force o_Current_State=00, o_Lives=0, o_Time_Left=0, o_Respawn=0, o_Clear_Score=0, o_Win=0, prescaler=0, death counter=0, and previous start sample=1.
REQ-035 Reset SHALL override all other inputs in any state, including mid-DEATH and mid-pulse.
REQ-036 After reset is released, the block SHALL be in IDLE and require a fresh start edge.

Verification (TICK_CYCLES=4, LEVEL_TIME=3, DEATH_TICKS=2, START_LIVES=2, WIN_SCORE=5)
REQ-037 Scenario 1: reset, then press start -> o_Current_State=01, o_Lives=2, o_Time_Left=3, and o_Clear_Score high for exactly 1 cycle.
REQ-038 Scenario 2: in PLAY, apply no input for 12 cycles -> o_Time_Left steps 3,2,1,0; at timeout o_Current_State=10, o_Lives=1, and one o_Respawn pulse; after 8 more cycles o_Current_State=01 and o_Time_Left=3.
REQ-039 Scenario 3: with o_Lives=1 in PLAY, pulse i_Collided -> o_Current_State=11, o_Lives=0, o_Win=0, and no o_Respawn; then press start -> 00.
REQ-040 Scenario 4: in PLAY, set i_Score=5 and i_Collided=1 in the same cycle -> o_Current_State=11, o_Win=1, and o_Lives unchanged.
REQ-041 Scenario 5: pulse i_Home_Reached on the same cycle as a tick with o_Time_Left=2 -> o_Time_Left=3; i_Collided during DEATH -> no change in o_Lives.
REQ-042 Scenario 6: hold i_Start_Btn high through reset release -> the block stays in 00; release then press -> 01; assert i_Reset mid-DEATH -> all outputs return to their REQ-034 values next cycle.
